// File: rtl/md_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operand width,
// funct3 operation codes, FSM state encoding and a conditional-negate helper.
package md_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // Two's-complement negate when neg is set; also yields |v| for signed v.
  function automatic logic [XLEN-1:0] md_cneg(input logic [XLEN-1:0] v,
                                              input logic            neg);
    return neg ? ((~v) + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// One radix-2 step of the shift-add multiplier / restoring divider plus its
// accumulators.
//   clk, rst      : clock, synchronous active-high reset
//   load_i        : initialise accumulators (hi=0, lo=lo_init_i, opnd=opnd_init_i)
//   step_i        : perform one iteration
//   div_i         : 1 = divide step, 0 = multiply step
//   lo_init_i     : multiplier (mul) or dividend (div) magnitude
//   opnd_init_i   : multiplicand (mul) or divisor (div) magnitude
//   hi_nxt_o      : high accumulator after this cycle's step (product hi / remainder)
//   lo_nxt_o      : low accumulator after this cycle's step (product lo / quotient)
module md_iter_core
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            div_i,
  input  logic [XLEN-1:0] lo_init_i,
  input  logic [XLEN-1:0] opnd_init_i,
  output logic [XLEN-1:0] hi_nxt_o,
  output logic [XLEN-1:0] lo_nxt_o
);

  logic [XLEN-1:0] hi_q, lo_q, opnd_q;
  logic [XLEN-1:0] hi_d, lo_d, opnd_d;
  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum, shifted, diff;
  logic [XLEN-1:0] hi_step, lo_step;

  always_comb begin
    // Multiply: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole 64-bit pair right.
    addend  = lo_q[0] ? opnd_q : '0;
    sum     = {1'b0, hi_q} + {1'b0, addend};
    // Divide: shift the next dividend bit into the remainder and trial-subtract.
    // The remainder stays below the divisor, so the borrow lands in bit XLEN.
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, opnd_q};
    if (div_i) begin
      hi_step = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_step = sum[XLEN:1];
      lo_step = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign hi_nxt_o = hi_step;
  assign lo_nxt_o = lo_step;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    if (load_i) begin
      hi_d   = '0;
      lo_d   = lo_init_i;
      opnd_d = opnd_init_i;
    end else if (step_i) begin
      hi_d = hi_step;
      lo_d = lo_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
//   clk, rst  : clock, synchronous active-high reset
//   StartE    : valid M-op in E
//   KillE     : abort current op (E flush)
//   MDOpE     : funct3 operation select
//   SrcAE     : rs1 after forwarding
//   SrcBE     : rs2 after forwarding
//   BusyE     : stall request to the hazard unit
//   DoneE     : one-cycle completion pulse
//   ResultE   : registered result, held until the next completion
module execute_muldiv_unit
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            StartE,
  input  logic            KillE,
  input  logic [2:0]      MDOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE
);

  md_state_e       state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic [2:0]      op_q, op_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            a_sgn, b_sgn, a_neg, b_neg, div0, ovf, special;
  logic [XLEN-1:0] a_abs, b_abs, spec_res;
  logic            core_load, core_step;
  logic [XLEN-1:0] hi_nxt, lo_nxt;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] mul_res, div_res, fin_res;

  // Operand decode on the incoming op.
  always_comb begin
    a_sgn    = (MDOpE != MD_MULHU) && (MDOpE != MD_DIVU) && (MDOpE != MD_REMU);
    b_sgn    = (MDOpE == MD_MUL) || (MDOpE == MD_MULH) ||
               (MDOpE == MD_DIV) || (MDOpE == MD_REM);
    a_neg    = a_sgn & SrcAE[XLEN-1];
    b_neg    = b_sgn & SrcBE[XLEN-1];
    a_abs    = md_cneg(SrcAE, a_neg);
    b_abs    = md_cneg(SrcBE, b_neg);
    div0     = (SrcBE == '0);
    ovf      = ((MDOpE == MD_DIV) || (MDOpE == MD_REM)) &&
               (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (SrcBE == '1);
    special  = MDOpE[2] & (div0 | ovf);
    spec_res = MDOpE[1] ? (div0 ? SrcAE : '0)
                        : (div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}});
  end

  md_iter_core u_core (
    .clk         (clk),
    .rst         (rst),
    .load_i      (core_load),
    .step_i      (core_step),
    .div_i       (op_q[2]),
    .lo_init_i   (MDOpE[2] ? a_abs : b_abs),
    .opnd_init_i (MDOpE[2] ? b_abs : a_abs),
    .hi_nxt_o    (hi_nxt),
    .lo_nxt_o    (lo_nxt)
  );

  // Sign fix-up applied to the last step's output so ResultE loads on the
  // ITER->DONE edge without an extra cycle.
  always_comb begin
    prod     = {hi_nxt, lo_nxt};
    prod_fix = neg_res_q ? ((~prod) + 64'd1) : prod;
    mul_res  = (op_q == MD_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    div_res  = op_q[1] ? md_cneg(hi_nxt, neg_rem_q) : md_cneg(lo_nxt, neg_res_q);
    fin_res  = op_q[2] ? div_res : mul_res;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    core_load = 1'b0;
    core_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (StartE && !KillE) begin
          op_d      = MDOpE;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          count_d   = '0;
          if (special) begin
            state_d  = DONE;
            result_d = spec_res;
          end else begin
            state_d   = ITER;
            core_load = 1'b1;
          end
        end
      end
      ITER: begin
        if (KillE) begin
          state_d = IDLE;
        end else begin
          core_step = 1'b1;
          count_d   = count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_d  = DONE;
            result_d = fin_res;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign BusyE   = ((state_q == IDLE) && StartE && !KillE) || (state_q == ITER);
  assign DoneE   = (state_q == DONE) && !KillE;
  assign ResultE = result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Scoreboard bench for execute_muldiv_unit: the driver pushes expected
// result and completion cycle per op; the monitor pops on every DoneE.
module tb_execute_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StartE = 1'b0;
  logic        KillE = 1'b0;
  logic [2:0]  MDOpE = 3'b000;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        BusyE, DoneE;
  logic [31:0] ResultE;

  execute_muldiv_unit dut (
    .clk     (clk),
    .rst     (rst),
    .StartE  (StartE),
    .KillE   (KillE),
    .MDOpE   (MDOpE),
    .SrcAE   (SrcAE),
    .SrcBE   (SrcBE),
    .BusyE   (BusyE),
    .DoneE   (DoneE),
    .ResultE (ResultE)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input longint act, input longint req);
    nchk++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Monitor: sample well after the falling edge so input changes have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (DoneE === 1'b1) begin
        if (exp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL spurious_done: got DoneE=1 at cycle %0d, required none", cyc);
        end else begin
          e = exp_q.pop_front();
          check({e.name, " result"}, longint'(ResultE), longint'(e.res));
          check({e.name, " done_cycle"}, cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input bit special);
    int n;
    int nb;
    @(negedge clk);
    MDOpE = op; SrcAE = a; SrcBE = b; StartE = 1'b1;
    n = cyc;
    exp_q.push_back('{nm, res, n + (special ? 1 : 33)});
    #1;
    nb = 0;
    while (BusyE === 1'b1 && nb < 100) begin
      nb++;
      @(negedge clk);
      StartE = 1'b0;
      #1;
    end
    check({nm, " busy_cycles"}, nb, special ? 1 : 33);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset BusyE", BusyE, 0);
    check("reset DoneE", DoneE, 0);
    check("reset ResultE", ResultE, 0);

    do_op("MUL 7*-3",         3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    do_op("MULHU -1*-1",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    do_op("MULH -1*-1",       3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    do_op("MULHSU -1*2",      3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0);
    do_op("MULH min*min",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    do_op("DIV -7/2",         3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 0);
    do_op("REM -7/2",         3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 0);
    do_op("DIVU 100/7",       3'b101, 32'd100,      32'd7,        32'd14,        0);
    do_op("REMU 100/7",       3'b111, 32'd100,      32'd7,        32'd2,         0);
    do_op("DIV 100/-7",       3'b100, 32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, 0);
    do_op("REM 100/-7",       3'b110, 32'd100,      32'hFFFF_FFF9, 32'd2,         0);
    do_op("DIVU 5/0",         3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    do_op("REMU 5/0",         3'b111, 32'd5,        32'd0,        32'd5,         1);
    do_op("DIV min/-1",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("REM min/-1",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // Back-to-back with StartE held through both DONE cycles.
    @(negedge clk);
    MDOpE = 3'b000; SrcAE = 32'd6; SrcBE = 32'd7; StartE = 1'b1;
    n = cyc;
    exp_q.push_back('{"MUL b2b first", 32'd42, n + 33});
    exp_q.push_back('{"MUL b2b second", 32'd42, n + 67});
    repeat (33) @(negedge clk);
    #1;
    check("b2b BusyE in first DONE", BusyE, 0);
    repeat (34) @(negedge clk);
    #1;
    check("b2b BusyE in second DONE", BusyE, 0);
    @(negedge clk);
    StartE = 1'b0;
    #1;
    check("b2b no restart BusyE", BusyE, 0);
    repeat (5) @(negedge clk);

    // Kill mid-ITER: no completion, ResultE keeps 42.
    @(negedge clk);
    MDOpE = 3'b000; SrcAE = 32'd3; SrcBE = 32'd5; StartE = 1'b1;
    @(negedge clk);
    StartE = 1'b0;
    repeat (9) @(negedge clk);
    KillE = 1'b1;
    @(negedge clk);
    KillE = 1'b0;
    #1;
    check("kill BusyE next cycle", BusyE, 0);
    repeat (40) @(negedge clk);
    check("kill ResultE held", ResultE, 32'd42);

    // Reset mid-ITER.
    @(negedge clk);
    MDOpE = 3'b101; SrcAE = 32'd100; SrcBE = 32'd7; StartE = 1'b1;
    @(negedge clk);
    StartE = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst BusyE", BusyE, 0);
    check("rst DoneE", DoneE, 0);
    check("rst ResultE", ResultE, 0);
    repeat (40) @(negedge clk);

    do_op("DIVU after rst",   3'b101, 32'd100,      32'd7,        32'd14,        0);
    repeat (5) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_unit.md
# execute_muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the decode/execute pipeline register. It takes an M-extension operation and its forwarded operands from the E stage. It runs a 32-step radix-2 shift-add multiply or restoring divide, and holds the pipeline through a busy/stall handshake with the hazard unit. On completion it delivers a 32-bit result to the E-stage result mux for one cycle.

## Interface
- XLEN, 32: operand/result width; only 32 is supported.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- StartE  in  1  a valid M-op is present in E (MDUnit decode bit from D/E register).
- KillE  in  1  abort the current op (E flush); sampled every cycle.
- MDOpE  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcAE  in  32  rs1 value after forwarding.
- SrcBE  in  32  rs2 value after forwarding.
- BusyE  out  1  stall request: hold F/D/E, bubble into M.
- DoneE  out  1  one-cycle pulse; ResultE valid.
- ResultE  out  32  registered result.

## Operation
- States: IDLE, ITER, DONE.
- IDLE:
  - If StartE & !KillE, latch op, |SrcAE|, |SrcBE|, result-sign and remainder-sign flags.
  - Clear count to 0, then go to ITER.
  - Special divides go straight to DONE:
    - divisor = 0: quotient 0xFFFFFFFF, remainder = SrcAE.
    - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- ITER:
  - Each cycle performs one shift-add (multiply, 64-bit accumulator) or one restore-subtract step (divide, 33-bit partial remainder).
  - count increments; after count = 31, go to DONE.
- DONE:
  - DoneE = 1.
  - ResultE is loaded on the IDLE→DONE or ITER→DONE edge.
  - Next state is always IDLE. StartE is ignored here, so the same instruction does not restart.
- Signedness:
  - MUL, MULH, DIV, REM treat both operands as signed.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - U variants treat both as unsigned.
- Result sign fix-up:
  - Product and quotient are negated when operand signs differ.
  - Remainder takes the sign of the dividend.
- Result selection:
  - MUL returns the low 32 bits.
  - MULH/MULHSU/MULHU return the high 32 bits of the 64-bit two's-complement product.
- BusyE = (state == IDLE & StartE & !KillE) | (state == ITER). It is combinational, and low in DONE so the pipeline advances that cycle.
- KillE in any state: next state IDLE, no DoneE, ResultE unchanged.
- rst has priority over KillE and StartE.

## Timing
- Reset values: state IDLE, count 0, DoneE 0, ResultE 0x00000000, BusyE 0. All internal operand/accumulator registers are cleared.
- Normal op: StartE seen in IDLE at cycle N.
  - ITER spans cycles N+1..N+32.
  - DONE at N+33.
  - BusyE is high for cycles N..N+32 (33 cycles).
- Special-case divide: BusyE high at N only; DONE at N+1.
- Back-to-back M-ops: the second is in E at N+34 and starts from IDLE. There is no dead cycle beyond DONE.
- StartE low in IDLE: no state change, BusyE 0.
- rst asserted mid-ITER: IDLE on the next edge, DoneE never pulses.
- ResultE holds its value until the next DONE load.

## Structure
- Shared package md_pkg holds:
  - MDOp funct3 localparams (MD_MUL … MD_REMU).
  - State enum encoding (IDLE=2'd0, ITER=2'd1, DONE=2'd2).
  - XLEN constant.
- Sub-module md_iter_core: one step of the shift-add/restore-subtract datapath plus accumulators.
- execute_muldiv_unit owns the FSM, operand abs/sign logic, special cases, and result fix-up.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), StartE at N -> BusyE high N..N+32, DoneE at N+33, ResultE 0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> ResultE 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF × 0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> ResultE 0xFFFFFFFF, DoneE at N+1. REMU 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, DoneE at N+1.
- KillE at N+10 -> IDLE at N+11, DoneE never asserts, ResultE keeps its prior value. rst at N+5 -> all outputs return to reset values next cycle.
- Two consecutive MULs with StartE held through DONE -> exactly two DoneE pulses (N+33, N+67), no spurious restart in DONE.
